// File: rtl/eee_imgproc_pkg.sv
// Shared definitions for the EEE image processor's slave register map and
// its message reader: addresses, message layout and the reader FSM states.
package eee_imgproc_pkg;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] READ_MSG   = 3'd1;
  localparam logic [2:0] READ_ID    = 3'd2;
  localparam logic [2:0] REG_BBCOL  = 3'd3;

  localparam int unsigned STATUS_FLUSH_BIT = 4;
  localparam logic [31:0] FLUSH_CMD        = 32'h1 << STATUS_FLUSH_BIT;

  // FIFO word count lives in status[15:8]
  localparam int unsigned STAT_CNT_LSB = 8;
  localparam int unsigned STAT_CNT_W   = 8;

  localparam logic [31:0] RBB_MSG_ID    = 32'h00524242;
  localparam logic [31:0] EEE_DEVICE_ID = 32'h1234EEE2;
  localparam logic [7:0]  MSG_WORDS     = 8'd3;

  localparam int unsigned X_LSB         = 16;
  localparam int unsigned Y_LSB         = 0;
  localparam int unsigned COORD_FIELD_W = 11;

  typedef enum logic [3:0] {
    S_ID_RD,
    S_ID_CAP,
    S_HALT,
    S_WAIT,
    S_ST_RD,
    S_ST_CAP,
    S_M_RD,
    S_M_CAP,
    S_DECODE,
    S_FLUSH
  } rd_state_t;

endpackage

// File: rtl/eee_msg_reader.sv
// Avalon-MM master that checks the image processor's device ID, polls its
// message FIFO and publishes each decoded "RBB" bounding box downstream.
module eee_msg_reader
  import eee_imgproc_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter logic [31:0] MSG_ID        = RBB_MSG_ID,
  parameter logic [31:0] DEVICE_ID     = EEE_DEVICE_ID,
  parameter int unsigned COORD_W       = COORD_FIELD_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic               m_chipselect,
  output logic               m_read,
  output logic               m_write,
  output logic [2:0]         m_address,
  output logic [31:0]        m_writedata,
  input  logic [31:0]        m_readdata,
  output logic [COORD_W-1:0] bb_left,
  output logic [COORD_W-1:0] bb_top,
  output logic [COORD_W-1:0] bb_right,
  output logic [COORD_W-1:0] bb_bottom,
  output logic               bb_valid,
  output logic               bb_empty,
  output logic               id_ok,
  output logic               id_err,
  output logic [7:0]         sync_err_count,
  output logic               busy
);

  localparam int unsigned     POLL_W    = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_INTERVAL - 1);

  rd_state_t          r_state, w_state_nx;
  logic               r_run;
  logic [POLL_W-1:0]  r_poll;
  logic [1:0]         r_wi;
  logic [31:0]        r_hdr;
  logic [COORD_W-1:0] r_x1, r_y1, r_x2, r_y2;
  logic [COORD_W-1:0] r_bb_left, r_bb_top, r_bb_right, r_bb_bottom;
  logic               r_bb_valid, r_bb_empty, r_id_ok, r_id_err;
  logic [7:0]         r_sync_err;

  logic w_poll_done, w_id_match, w_hdr_ok, w_msg_ready;

  assign w_poll_done = enable && (r_poll == POLL_LAST);
  assign w_id_match  = (m_readdata == DEVICE_ID);
  assign w_hdr_ok    = (r_hdr == MSG_ID);
  assign w_msg_ready = (m_readdata[STAT_CNT_LSB +: STAT_CNT_W] >= MSG_WORDS);

  // Bus strobes decode straight from the state so each read lasts exactly one
  // cycle; r_run keeps the bus quiet in the first cycle after reset.
  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves a value unassigned (which would infer a latch).
  always_comb begin
    w_state_nx   = r_state;
    m_chipselect = 1'b0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = REG_STATUS;
    m_writedata  = '0;
    case (r_state)
      S_ID_RD: begin
        if (r_run) begin
          m_chipselect = 1'b1;
          m_read       = 1'b1;
          m_address    = READ_ID;
          w_state_nx   = S_ID_CAP;
        end
      end
      S_ID_CAP: w_state_nx = w_id_match ? S_WAIT : S_HALT;
      S_HALT:   w_state_nx = S_HALT;
      S_WAIT:   if (w_poll_done) w_state_nx = S_ST_RD;
      S_ST_RD: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = REG_STATUS;
        w_state_nx   = S_ST_CAP;
      end
      S_ST_CAP: w_state_nx = w_msg_ready ? S_M_RD : S_WAIT;
      S_M_RD: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = READ_MSG;
        w_state_nx   = S_M_CAP;
      end
      S_M_CAP:  w_state_nx = (r_wi == 2'd2) ? S_DECODE : S_M_RD;
      S_DECODE: w_state_nx = w_hdr_ok ? S_ST_RD : S_FLUSH;
      S_FLUSH: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_address    = REG_STATUS;
        m_writedata  = FLUSH_CMD;
        w_state_nx   = S_WAIT;
      end
      default:  w_state_nx = S_ID_RD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_ID_RD;
      r_run       <= 1'b0;
      r_poll      <= '0;
      r_wi        <= '0;
      r_bb_left   <= '0;
      r_bb_top    <= '0;
      r_bb_right  <= '0;
      r_bb_bottom <= '0;
      r_bb_valid  <= 1'b0;
      r_bb_empty  <= 1'b0;
      r_id_ok     <= 1'b0;
      r_id_err    <= 1'b0;
      r_sync_err  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_run      <= 1'b1;
      r_bb_valid <= 1'b0;
      case (r_state)
        S_ID_CAP: begin
          if (w_id_match) r_id_ok  <= 1'b1;
          else            r_id_err <= 1'b1;
        end
        S_WAIT: begin
          if (enable) r_poll <= w_poll_done ? '0 : r_poll + POLL_W'(1);
        end
        S_ST_CAP: r_wi <= '0;
        S_M_CAP:  if (r_wi != 2'd2) r_wi <= r_wi + 2'd1;
        S_DECODE: begin
          if (w_hdr_ok) begin
            r_bb_left   <= r_x1;
            r_bb_top    <= r_y1;
            r_bb_right  <= r_x2;
            r_bb_bottom <= r_y2;
            r_bb_valid  <= 1'b1;
            r_bb_empty  <= (r_x1 > r_x2) || (r_y1 > r_y2);
          end else if (r_sync_err != 8'hFF) begin
            r_sync_err <= r_sync_err + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the captured message words are pure datapath, always written before
  // DECODE reads them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_M_CAP) begin
      case (r_wi)
        2'd0: r_hdr <= m_readdata;
        2'd1: begin
          r_x1 <= m_readdata[X_LSB +: COORD_W];
          r_y1 <= m_readdata[Y_LSB +: COORD_W];
        end
        default: begin
          r_x2 <= m_readdata[X_LSB +: COORD_W];
          r_y2 <= m_readdata[Y_LSB +: COORD_W];
        end
      endcase
    end
  end

  assign bb_left        = r_bb_left;
  assign bb_top         = r_bb_top;
  assign bb_right       = r_bb_right;
  assign bb_bottom      = r_bb_bottom;
  assign bb_valid       = r_bb_valid;
  assign bb_empty       = r_bb_empty;
  assign id_ok          = r_id_ok;
  assign id_err         = r_id_err;
  assign sync_err_count = r_sync_err;
  assign busy           = r_run && (r_state != S_WAIT) && (r_state != S_HALT);

endmodule

// File: tb/tb_eee_msg_reader.sv
// Bench for eee_msg_reader: a behavioural image-processor slave with message
// FIFO, a box scoreboard fed by the stimulus and drained by a bus monitor.
module tb_eee_msg_reader;
  import eee_imgproc_pkg::*;

  localparam int unsigned POLL = 16;
  localparam int unsigned CW   = 11;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          m_chipselect, m_read, m_write;
  logic [2:0]    m_address;
  logic [31:0]   m_writedata;
  logic [31:0]   m_readdata = 32'h0;
  logic [CW-1:0] bb_left, bb_top, bb_right, bb_bottom;
  logic          bb_valid, bb_empty, id_ok, id_err, busy;
  logic [7:0]    sync_err_count;

  always #5 clk = ~clk;

  eee_msg_reader #(
    .POLL_INTERVAL(POLL),
    .MSG_ID       (RBB_MSG_ID),
    .DEVICE_ID    (EEE_DEVICE_ID),
    .COORD_W      (CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .m_chipselect  (m_chipselect),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .bb_left       (bb_left),
    .bb_top        (bb_top),
    .bb_right      (bb_right),
    .bb_bottom     (bb_bottom),
    .bb_valid      (bb_valid),
    .bb_empty      (bb_empty),
    .id_ok         (id_ok),
    .id_err        (id_err),
    .sync_err_count(sync_err_count),
    .busy          (busy)
  );

  typedef struct {
    logic [CW-1:0] l, t, r, b;
    logic          e;
  } box_t;

  box_t        exp_q[$];
  box_t        last_box;
  int          box_cyc[$];
  logic [31:0] fifo[$];
  logic [31:0] id_val = 32'h0;
  int          force_count = -1;

  int   n_cmp = 0, n_err = 0;
  int   n_reads = 0, n_msg_reads = 0, n_st_reads = 0, n_pops = 0;
  int   n_writes = 0, n_boxes = 0, viol = 0, cyc = 0;
  logic slv_prev_rd = 1'b0;
  logic mon_prev_rd = 1'b0;
  logic mon_prev_bv = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Image-processor slave: registered read data, edge-detected FIFO pop.
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    slv_prev_rd <= m_read;
    if (m_chipselect && m_read) begin
      n_reads <= n_reads + 1;
      case (m_address)
        REG_STATUS: begin
          n_st_reads <= n_st_reads + 1;
          m_readdata <= {16'h0, (force_count >= 0) ? 8'(force_count) : 8'(fifo.size()), 8'h0};
        end
        READ_MSG: begin
          n_msg_reads <= n_msg_reads + 1;
          if (!slv_prev_rd && fifo.size() > 0) begin
            m_readdata <= fifo[0];
            fifo.delete(0);
            n_pops <= n_pops + 1;
          end else begin
            m_readdata <= 32'h0;
          end
        end
        READ_ID: m_readdata <= id_val;
        default: m_readdata <= 32'h0;
      endcase
    end
    if (m_chipselect && m_write && m_address == REG_STATUS && m_writedata[STATUS_FLUSH_BIT])
      fifo.delete();
  end

  // Monitor: protocol rules, flush writes, and the box scoreboard.
  always @(negedge clk) begin
    if (m_read && mon_prev_rd) viol++;
    if (!m_write && m_writedata != 32'h0) viol++;
    if (bb_valid && mon_prev_bv) viol++;
    mon_prev_rd = m_read;
    mon_prev_bv = bb_valid;
    if (m_write) begin
      n_writes++;
      check("flush_write", {29'h0, m_address, m_writedata}, {29'h0, REG_STATUS, FLUSH_CMD});
    end
    if (bb_valid) begin
      n_boxes++;
      box_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL box_unexpected: actual l=%0d t=%0d r=%0d b=%0d required none",
                 bb_left, bb_top, bb_right, bb_bottom);
      end else begin
        box_t e;
        e = exp_q.pop_front();
        check("box", {bb_left, bb_top, bb_right, bb_bottom, bb_empty}, {e.l, e.t, e.r, e.b, e.e});
      end
    end
  end

  function automatic logic [31:0] xy(input int x, input int y);
    return {5'd0, 11'(x), 5'd0, 11'(y)};
  endfunction

  task automatic push_msg(input logic [31:0] h, input logic [31:0] w1, input logic [31:0] w2);
    fifo.push_back(h);
    fifo.push_back(w1);
    fifo.push_back(w2);
  endtask

  task automatic expect_box(input int l, input int t, input int r, input int b);
    box_t e;
    e.l = CW'(l);
    e.t = CW'(t);
    e.r = CW'(r);
    e.b = CW'(b);
    e.e = (l > r) || (t > b);
    exp_q.push_back(e);
    last_box = e;
  endtask

  task automatic wait_boxes(input int target, input string name);
    int i = 0;
    while (n_boxes < target && i < 400) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(n_boxes >= target), 64'd1);
  endtask

  task automatic wait_msg_read(input string name);
    int i = 0;
    while (!(m_read && m_address == READ_MSG) && i < 400) begin
      @(negedge clk);
      i++;
    end
    check(name, {63'h0, m_read}, 64'd1);
  endtask

  task automatic do_reset(input logic [31:0] id);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    fifo.delete();
    force_count = -1;
    id_val      = id;
    reset_n     = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus"}, {m_chipselect, m_read, m_write, m_address, m_writedata}, 64'h0);
    check({tag, "_out"}, {bb_left, bb_top, bb_right, bb_bottom, bb_valid, bb_empty,
                          id_ok, id_err, sync_err_count, busy}, 64'h0);
  endtask

  task automatic check_bb_hold(input string name);
    check(name, {bb_left, bb_top, bb_right, bb_bottom},
          {last_box.l, last_box.t, last_box.r, last_box.b});
  endtask

  initial begin
    int i, c, r0, p0, m0, s0, w0;
    reset_n = 1'b0;
    enable  = 1'b1;

    // Reset state, then a mismatched device ID halts the reader.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    r0      = n_reads;
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("id_err_set", {63'h0, id_err}, 64'd1);
    check("id_ok_clear", {63'h0, id_ok}, 64'd0);
    check("halt_reads", 64'(n_reads - r0), 64'd1);
    check("halt_idle", {m_chipselect, busy}, 64'd0);

    // Matching ID: id_ok, then the first status poll POLL cycles later.
    do_reset(EEE_DEVICE_ID);
    i = 0;
    while (!id_ok && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("id_ok_set", {63'h0, id_ok}, 64'd1);
    check("id_err_clear", {63'h0, id_err}, 64'd0);
    c = 0;
    while (!(m_read && m_address == REG_STATUS) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("first_poll_gap", 64'(c), 64'(POLL));

    // Nominal message.
    p0 = n_pops;
    push_msg(RBB_MSG_ID, xy(100, 50), xy(200, 150));
    expect_box(100, 50, 200, 150);
    wait_boxes(1, "box1_seen");
    @(negedge clk);
    check("bb_valid_pulse", {63'h0, bb_valid}, 64'd0);
    check("nominal_pops", 64'(n_pops - p0), 64'd3);
    check("nominal_fifo_empty", 64'(fifo.size()), 64'd0);

    // Empty frame with junk in the ignored bits, then two back-to-back messages.
    push_msg(RBB_MSG_ID, {5'h1F, 11'd639, 5'h1F, 11'd0}, 32'h0);
    expect_box(639, 0, 0, 0);
    wait_boxes(2, "box2_seen");
    push_msg(RBB_MSG_ID, xy(10, 20), xy(30, 40));
    push_msg(RBB_MSG_ID, xy(5, 5), xy(5, 4));
    expect_box(10, 20, 30, 40);
    expect_box(5, 5, 5, 4);
    wait_boxes(4, "box4_seen");
    check("drain_gap", 64'(box_cyc[3] - box_cyc[2]), 64'd9);

    // Two words queued: no message reads until the third arrives.
    repeat (4) @(negedge clk);
    m0 = n_msg_reads;
    fifo.push_back(RBB_MSG_ID);
    fifo.push_back(xy(7, 8));
    s0 = n_st_reads;
    i  = 0;
    while (n_st_reads < s0 + 2 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("below_threshold_polls", 64'(n_st_reads >= s0 + 2), 64'd1);
    check("below_threshold_no_msg", 64'(n_msg_reads - m0), 64'd0);
    fifo.push_back(xy(9, 10));
    expect_box(7, 8, 9, 10);
    wait_boxes(5, "box5_seen");
    check("threshold_msg_reads", 64'(n_msg_reads - m0), 64'd3);

    // Bad header: one error, one flush, box outputs unchanged.
    w0 = n_writes;
    push_msg(32'h00000007, xy(1, 2), xy(3, 4));
    i = 0;
    while (n_writes == w0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    check("desync_count", 64'(sync_err_count), 64'd1);
    check("desync_one_flush", 64'(n_writes - w0), 64'd1);
    check("desync_fifo_cleared", 64'(fifo.size()), 64'd0);
    check_bb_hold("desync_bb_hold");

    // Status claims 3 words over an empty FIFO: zero headers until saturation.
    force_count = 3;
    w0 = n_writes;
    i  = 0;
    while (n_writes - w0 < 300 && i < 300 * 40) begin
      @(negedge clk);
      i++;
    end
    force_count = -1;
    repeat (40) @(negedge clk);
    check("forced_flushes", 64'(n_writes - w0 >= 300), 64'd1);
    check("sync_saturated", 64'(sync_err_count), 64'd255);
    check_bb_hold("saturate_bb_hold");

    // enable dropped mid-message: the message completes, then the bus goes quiet.
    push_msg(RBB_MSG_ID, xy(11, 12), xy(13, 14));
    expect_box(11, 12, 13, 14);
    wait_msg_read("enable_msg_started");
    enable = 1'b0;
    wait_boxes(6, "box6_seen");
    repeat (10) @(negedge clk);
    r0 = n_reads;
    repeat (5 * POLL) @(negedge clk);
    check("disabled_no_reads", 64'(n_reads - r0), 64'd0);
    check("disabled_not_busy", {63'h0, busy}, 64'd0);
    enable = 1'b1;

    // Reset landing in M_CAP clears everything and restarts at the ID read.
    push_msg(RBB_MSG_ID, xy(1, 1), xy(2, 2));
    wait_msg_read("mcap_msg_started");
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("reset_mcap");
    @(negedge clk);
    fifo.delete();
    reset_n = 1'b1;
    i = 0;
    while (!m_read && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("restart_id_addr", {61'h0, m_address}, {61'h0, READ_ID});
    i = 0;
    while (!id_ok && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("restart_id_ok", {63'h0, id_ok}, 64'd1);

    repeat (5) @(negedge clk);
    check("protocol_violations", 64'(viol), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/eee_msg_reader.md
Name: eee_msg_reader

Overview:
- Avalon-MM master that consumes the image processor's message FIFO over its slave port; it is the reader for that writer.
- Verifies the device ID once after reset, then polls the status register.
- When a whole message is queued, it reads the three words, checks the "RBB" header and publishes the bounding box to downstream logic (servo/steering control).
- On a header mismatch it flushes the FIFO to resynchronise.

Parameters:
- POLL_INTERVAL, 1024: idle cycles between status polls (min 1).
- MSG_ID, 32'h00524242: expected header word ("RBB").
- DEVICE_ID, 32'h1234EEE2: expected value at the ID register.
- COORD_W, 11: coordinate field width.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- enable  in  1  allow polling
- m_chipselect  out  1  slave select
- m_read  out  1  read strobe
- m_write  out  1  write strobe
- m_address  out  3  register address (0 status, 1 msg, 2 id)
- m_writedata  out  32  write data
- m_readdata  in  32  slave read data, valid the cycle after the read strobe
- bb_left, bb_top, bb_right, bb_bottom  out  COORD_W each  last decoded box
- bb_valid  out  1  one-cycle pulse when the box updates
- bb_empty  out  1  last box had left>right or top>bottom
- id_ok  out  1  device ID matched
- id_err  out  1  device ID mismatched; block halted
- sync_err_count  out  8  header mismatches, saturating
- busy  out  1  FSM not in WAIT/HALT

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0 and FSM=ID_RD. This applies equally mid-transaction, with no bus cleanup. Clock domain is clk only.
- Bus timing:
  - A read is 2 cycles. *_RD drives chipselect=read=1 and the address. *_CAP drives read=0 and samples m_readdata.
  - read is never high in two consecutive cycles. This guarantees the slave's edge-detected FIFO pop fires exactly once per message read.
  - The write is 1 cycle: chipselect=write=1.
- FSM states and transitions:
  - ID_RD -> ID_CAP.
  - ID_CAP: if data==DEVICE_ID, set id_ok=1 and go to WAIT. Otherwise set id_err=1 and go to HALT.
  - HALT: terminal until reset; bus stays idle.
  - WAIT:
    - Poll counter counts 0..POLL_INTERVAL-1 while enable=1.
    - The counter holds while enable=0.
    - At terminal count, clear the counter and go to ST_RD.
    - enable is sampled only here; deasserting it elsewhere lets the current message finish.
  - ST_RD -> ST_CAP.
  - ST_CAP:
    - Let n = data[15:8] (FIFO word count).
    - If n>=3, clear the word index wi to 0 and go to M_RD. Otherwise go to WAIT.
  - M_RD (address 1) -> M_CAP.
  - M_CAP:
    - Store the word into w[wi].
    - If wi==2, go to DECODE. Otherwise increment wi and go to M_RD.
  - DECODE:
    - If w0==MSG_ID, load bb_left=w1[26:16], bb_top=w1[10:0], bb_right=w2[26:16], bb_bottom=w2[10:0].
    - In the same case, pulse bb_valid (1 cycle, coincident with the register update) and set bb_empty = (w1[26:16]>w2[26:16]) | (w1[10:0]>w2[10:0]). Then go to ST_RD to drain any backlog without waiting.
    - Otherwise increment sync_err_count (saturating at 255), leave the bb_* outputs unchanged and go to FLUSH.
  - FLUSH: write 32'h00000010 to address 0, which clears the FIFO, then go to WAIT.
- Bits 31:27 and 15:11 of the coordinate words are ignored.
- If the FIFO empties underneath the reader (e.g. an external flush), it reads stale or zero words. These fail the header check and cause a flush plus an error count, with no lock-up.
- m_writedata is 0 whenever write=0.

Decomposition:
- Shared package eee_imgproc_pkg holds:
  - register addresses REG_STATUS=0, READ_MSG=1, READ_ID=2, REG_BBCOL=3;
  - STATUS_FLUSH_BIT=4;
  - status count field [15:8];
  - RBB_MSG_ID and DEVICE_ID constants;
  - coordinate field positions;
  - FSM state enum.
- Single module. The FSM is small, so no sub-module.
- The bench reuses EEE_IMGPROC's slave port plus MSG_FIFO as the DUT's counterpart.

Test Plan:
1. ID check: reset release, ID reg returns 32'h1234EEE2 -> id_ok=1 after 2 cycles, first status read issued POLL_INTERVAL cycles later. A mismatched ID of 32'h0 -> id_err=1, bus idle forever.
2. Nominal message: FIFO holds "RBB", {x=100,y=50}, {x=200,y=150} -> exactly 3 pops, bb_left=100, bb_top=50, bb_right=200, bb_bottom=150, bb_valid high for 1 cycle, bb_empty=0.
3. Empty-frame box: words {639,0},{0,0} -> bb_valid pulse, bb_empty=1. Two queued messages -> two bb_valid pulses with no poll gap between them.
4. Count below threshold: status count=2 -> no READ_MSG access, return to WAIT; count=3 on the next poll -> message read.
5. Desync: header word 32'h00000007 -> sync_err_count 0->1, flush write of 0x10 to address 0, bb_* unchanged. 300 forced errors -> count saturates at 255.
6. Protocol/reset: check m_read never high two consecutive cycles across the whole run. Assert reset_n in M_CAP -> all outputs 0 next cycle, restart from ID_RD. enable=0 -> no bus activity after the current message.
